// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master and apb4_mem_slave.
// PPROT is present only when APB4_MEM_SLAVE_PROT_EN is defined.
interface apb4_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
`ifdef APB4_MEM_SLAVE_PROT_EN
  logic [2:0]              PPROT;
`endif

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
`ifdef APB4_MEM_SLAVE_PROT_EN
    output PPROT,
`endif
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
`ifdef APB4_MEM_SLAVE_PROT_EN
    input  PPROT,
`endif
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_mem_slave.sv
// Parametrised APB4 memory slave with wait states, byte strobes and PSLVERR.
// Optional APB4_MEM_SLAVE_PROT_EN: rejects unprivileged writes (PPROT[0]=0).
module apb4_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}},
  parameter int                    WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  apb4_mem_slave_if.slave      bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH+1)'(DEPTH * STRB_W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // The borrow of a below-base address lands in the top bit, so one compare covers both ends.
  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    return (diff >= MEM_BYTES) || ((addr & ALIGN_MASK) != {ADDR_WIDTH{1'b0}});
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    offset = (addr - BASE_ADDR) >> OFF_W;
    return offset[IDX_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  write_r;
  logic                  priv_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_W-1:0]     strb_r;
  logic [DATA_WIDTH-1:0] prdata_r;
  logic                  pready_r;
  logic                  pslverr_r;

  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic                  sel_write_s;
  logic                  sel_priv_s;
  logic                  sel_err_s;
  logic [DATA_WIDTH-1:0] resp_data_s;
  logic                  we_s;
  logic                  setup_priv_s;

`ifdef APB4_MEM_SLAVE_PROT_EN
  assign setup_priv_s = bus.PPROT[0];
`else
  assign setup_priv_s = 1'b1;
`endif

  // Response source: live bus when answering on the SETUP edge, latched copy otherwise.
  always_comb begin
    sel_addr_s  = addr_r;
    sel_write_s = write_r;
    sel_priv_s  = priv_r;
    if (state_r == ST_IDLE) begin
      sel_addr_s  = bus.PADDR;
      sel_write_s = bus.PWRITE;
      sel_priv_s  = setup_priv_s;
    end else begin
      sel_addr_s  = addr_r;
      sel_write_s = write_r;
      sel_priv_s  = priv_r;
    end
    sel_err_s = addr_bad(sel_addr_s) || (sel_write_s && !sel_priv_s);
    if (sel_err_s || sel_write_s) begin
      resp_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      resp_data_s = mem_r[word_idx(sel_addr_s)];
    end
  end

  // Commit only on the completing edge of an error-free write.
  always_comb begin
    we_s = 1'b0;
    if ((state_r == ST_ACCESS) && pready_r && bus.PSEL && bus.PENABLE && write_r && !pslverr_r) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Byte-lane write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_r[i]) begin
          mem_r[word_idx(addr_r)][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  // Transfer FSM with registered PREADY/PRDATA/PSLVERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      write_r   <= 1'b0;
      priv_r    <= 1'b0;
      wdata_r   <= {DATA_WIDTH{1'b0}};
      strb_r    <= {STRB_W{1'b0}};
      prdata_r  <= {DATA_WIDTH{1'b0}};
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            addr_r  <= bus.PADDR;
            write_r <= bus.PWRITE;
            priv_r  <= setup_priv_s;
            wdata_r <= bus.PWDATA;
            strb_r  <= bus.PSTRB;
            cnt_r   <= WAIT_INIT;
            state_r <= ST_ACCESS;
            if (WAIT_INIT == 4'd0) begin
              pready_r  <= 1'b1;
              prdata_r  <= resp_data_s;
              pslverr_r <= sel_err_s;
            end else begin
              pready_r  <= 1'b0;
              prdata_r  <= {DATA_WIDTH{1'b0}};
              pslverr_r <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (!bus.PSEL) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b0;
            prdata_r  <= {DATA_WIDTH{1'b0}};
            pslverr_r <= 1'b0;
          end else if (!pready_r) begin
            if (cnt_r > 4'd1) begin
              cnt_r <= cnt_r - 4'd1;
            end else begin
              cnt_r     <= 4'd0;
              pready_r  <= 1'b1;
              prdata_r  <= resp_data_s;
              pslverr_r <= sel_err_s;
            end
          end else if (bus.PENABLE) begin
            state_r   <= ST_IDLE;
            pready_r  <= 1'b0;
            prdata_r  <= {DATA_WIDTH{1'b0}};
            pslverr_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= 4'd0;
          pready_r  <= 1'b0;
          prdata_r  <= {DATA_WIDTH{1'b0}};
          pslverr_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PRDATA  = prdata_r;
  assign bus.PREADY  = pready_r;
  assign bus.PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: two instances (0 and 3 wait states) checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_apb4_mem_slave;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;

  logic clk;
  logic rst;

  apb4_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  apb4_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();

  apb4_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
                   .BASE_ADDR(BASE), .WAIT_STATES(WS0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  apb4_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
                   .BASE_ADDR(BASE), .WAIT_STATES(WS1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: per-instance memory image and current expected response.
  logic [31:0] mdl_mem   [2][DEPTH];
  bit          mdl_known [2][DEPTH];
  logic        exp_err    [2];
  logic [31:0] exp_rdata  [2];
  bit          exp_rknown [2];
  int          acc_cnt    [2];
  bit          chk_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_port(input int w, input logic psel, input logic pen,
                            input logic rdy, input logic [31:0] rdata, input logic err);
    int  ws;
    bit  exp_rdy;
    ws = (w == 0) ? WS0 : WS1;
    if (psel && pen) begin
      exp_rdy = (acc_cnt[w] >= ws);
      chk($sformatf("pready[%0d]", w), {31'd0, rdy}, {31'd0, exp_rdy});
      if (exp_rdy) begin
        chk($sformatf("pslverr[%0d]", w), {31'd0, err}, {31'd0, exp_err[w]});
        if (exp_rknown[w]) chk($sformatf("prdata[%0d]", w), rdata, exp_rdata[w]);
      end else begin
        chk($sformatf("prdata_wait[%0d]", w), rdata, 32'd0);
        chk($sformatf("pslverr_wait[%0d]", w), {31'd0, err}, 32'd0);
      end
      acc_cnt[w]++;
    end else begin
      acc_cnt[w] = 0;
      chk($sformatf("idle_pready[%0d]", w), {31'd0, rdy}, 32'd0);
      chk($sformatf("idle_prdata[%0d]", w), rdata, 32'd0);
      chk($sformatf("idle_pslverr[%0d]", w), {31'd0, err}, 32'd0);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check_port(0, b0.PSEL, b0.PENABLE, b0.PREADY, b0.PRDATA, b0.PSLVERR);
      check_port(1, b1.PSEL, b1.PENABLE, b1.PREADY, b1.PRDATA, b1.PSLVERR);
    end else begin
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
    end
  end

  task automatic drive(input int w, input logic sel, input logic en, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wd, input logic [3:0] st,
                       input logic [2:0] prot);
    if (w == 0) begin
      b0.PSEL = sel; b0.PENABLE = en; b0.PADDR = addr; b0.PWRITE = wr;
      b0.PWDATA = wd; b0.PSTRB = st;
`ifdef APB4_MEM_SLAVE_PROT_EN
      b0.PPROT = prot;
`endif
    end else begin
      b1.PSEL = sel; b1.PENABLE = en; b1.PADDR = addr; b1.PWRITE = wr;
      b1.PWDATA = wd; b1.PSTRB = st;
`ifdef APB4_MEM_SLAVE_PROT_EN
      b1.PPROT = prot;
`endif
    end
  endtask

  // One APB transfer starting with SETUP immediately; returns with the bus idle just after the completing edge.
  task automatic xfer(input int w, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] prot,
                      output logic [31:0] rd, output logic er, output int waits);
    bit     bad;
    bit     got;
    int     idx;
    longint a;
    a   = longint'(addr);
    bad = (a < longint'(BASE)) || (a >= longint'(BASE) + DEPTH * 4) || (addr[1:0] != 2'b00);
`ifdef APB4_MEM_SLAVE_PROT_EN
    if (wr && !prot[0]) bad = 1'b1;
`endif
    idx = bad ? 0 : int'((a - longint'(BASE)) / 4);
    exp_err[w]    = bad;
    exp_rknown[w] = wr || bad || mdl_known[w][idx];
    exp_rdata[w]  = (wr || bad) ? 32'd0 : mdl_mem[w][idx];
    drive(w, 1'b1, 1'b0, addr, wr, wd, st, prot);
    @(posedge clk); #1;
    drive(w, 1'b1, 1'b1, addr, wr, wd, st, prot);
    waits = 0; rd = 32'd0; er = 1'b0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((w == 0) ? b0.PREADY : b1.PREADY) begin
        got = 1'b1;
        rd  = (w == 0) ? b0.PRDATA : b1.PRDATA;
        er  = (w == 0) ? b0.PSLVERR : b1.PSLVERR;
        break;
      end
      waits++;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL timeout[%0d]: PREADY never rose, expected within 40 cycles", w);
    end
    @(posedge clk); #1;
    if (wr && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (st[i]) mdl_mem[w][idx][8*i +: 8] = wd[8*i +: 8];
      end
      if (st == 4'hF) mdl_known[w][idx] = 1'b1;
    end
    drive(w, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 3'b001);
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mdl_mem[w][i]   = 32'd0;
        mdl_known[w][i] = 1'b0;
      end
      exp_err[w] = 1'b0; exp_rdata[w] = 32'd0; exp_rknown[w] = 1'b0; acc_cnt[w] = 0;
    end
    chk_on = 1'b1;
    rst    = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 3'b001);
    drive(1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 3'b001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pready", {31'd0, b0.PREADY}, 32'd0);
    chk("reset_prdata", b0.PRDATA, 32'd0);
    chk("reset_pslverr", {31'd0, b1.PSLVERR}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write/read, zero wait states
    xfer(0, BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, rd, er, wt);
    chk("ws0_write_waits", wt, 32'd0);
    chk("ws0_write_err", {31'd0, er}, 32'd0);
    xfer(0, BASE + 32'h10, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("ws0_read_data", rd, 32'hDEAD_BEEF);
    chk("ws0_read_waits", wt, 32'd0);

    // Three wait states
    xfer(1, BASE + 32'h8, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b001, rd, er, wt);
    chk("ws3_write_waits", wt, 32'd3);
    xfer(1, BASE + 32'h8, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("ws3_read_waits", wt, 32'd3);
    chk("ws3_read_data", rd, 32'h0BAD_F00D);

    // Byte-lane merge
    xfer(0, BASE + 32'h20, 1'b1, 32'h1122_3344, 4'hF, 3'b001, rd, er, wt);
    xfer(0, BASE + 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101, 3'b001, rd, er, wt);
    xfer(0, BASE + 32'h20, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("strobe_merge", rd, 32'h11BB_33DD);

    // Error responses leave memory untouched
    xfer(0, BASE, 1'b1, 32'hA5A5_0000, 4'hF, 3'b001, rd, er, wt);
    xfer(0, BASE + (DEPTH - 1) * 4, 1'b1, 32'h0000_5A5A, 4'hF, 3'b001, rd, er, wt);
    xfer(0, BASE + DEPTH * 4, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, er, wt);
    chk("err_above", {31'd0, er}, 32'd1);
    xfer(0, BASE + 32'h2, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, er, wt);
    chk("err_misaligned", {31'd0, er}, 32'd1);
    xfer(0, BASE - 32'h4, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("err_below", {31'd0, er}, 32'd1);
    chk("err_below_data", rd, 32'd0);
    xfer(1, BASE + DEPTH * 4, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("err_ws3_waits", wt, 32'd3);
    chk("err_ws3_flag", {31'd0, er}, 32'd1);
    xfer(0, BASE, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("word0_kept", rd, 32'hA5A5_0000);
    xfer(0, BASE + (DEPTH - 1) * 4, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("wordlast_kept", rd, 32'h0000_5A5A);

    // Back-to-back write then read, and a zero-strobe write
    xfer(0, BASE + 32'h30, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b001, rd, er, wt);
    xfer(0, BASE + 32'h30, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("b2b_read", rd, 32'hCAFE_F00D);
    xfer(0, BASE + 32'h30, 1'b1, 32'h0000_0000, 4'h0, 3'b001, rd, er, wt);
    chk("strb0_err", {31'd0, er}, 32'd0);
    xfer(0, BASE + 32'h30, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("strb0_kept", rd, 32'hCAFE_F00D);

    // Reset asserted during the ACCESS phase of a write
    chk_on = 1'b0;
    drive(0, 1'b1, 1'b0, BASE + 32'h10, 1'b1, 32'h1234_5678, 4'hF, 3'b001);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, BASE + 32'h10, 1'b1, 32'h1234_5678, 4'hF, 3'b001);
    @(negedge clk);
    chk("pre_rst_pready", {31'd0, b0.PREADY}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pready", {31'd0, b0.PREADY}, 32'd0);
    chk("async_rst_pslverr", {31'd0, b0.PSLVERR}, 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 3'b001);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    @(posedge clk); #1;
    xfer(0, BASE + 32'h10, 1'b0, 32'd0, 4'h0, 3'b001, rd, er, wt);
    chk("rst_write_lost", rd, 32'hDEAD_BEEF);

`ifdef APB4_MEM_SLAVE_PROT_EN
    // Unprivileged write rejected, privileged write accepted
    xfer(0, BASE + 32'h10, 1'b1, 32'h0101_0101, 4'hF, 3'b000, rd, er, wt);
    chk("prot_unpriv_err", {31'd0, er}, 32'd1);
    xfer(0, BASE + 32'h10, 1'b0, 32'd0, 4'h0, 3'b000, rd, er, wt);
    chk("prot_unpriv_kept", rd, 32'hDEAD_BEEF);
    xfer(0, BASE + 32'h10, 1'b1, 32'h0202_0202, 4'hF, 3'b001, rd, er, wt);
    chk("prot_priv_ok", {31'd0, er}, 32'd0);
    xfer(0, BASE + 32'h10, 1'b0, 32'd0, 4'h0, 3'b000, rd, er, wt);
    chk("prot_priv_data", rd, 32'h0202_0202);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
